// File: rtl/axi2ahb_wr_ctrl.sv
// axi2ahb_wr_ctrl: AHB write-burst sequencer for the AXI-to-AHB bridge.
// Issues INCR bursts once a full burst is buffered; drains error commands.
module axi2ahb_wr_ctrl #(
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   input  logic [ADDR_BITS-1:0] cmd_addr,
   input  logic [LEN_BITS-1:0]  cmd_len,
   input  logic [1:0]           cmd_size,
   input  logic                 cmd_err,
   output logic                 cmd_pop,
   input  logic                 wdata_ready,
   output logic [ADDR_BITS-1:0] HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   input  logic                 HREADY,
   output logic                 wdata_phase,
   output logic                 data_last,
   output logic                 busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_BURST = 3'd2;
   localparam logic [2:0] S_DEND  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [ADDR_BITS-1:0] addr;
   logic [LEN_BITS-1:0]  len;
   logic [LEN_BITS-1:0]  cnt;
   logic [1:0]           size;
   logic                 dphase;
   logic                 dlast;
   logic                 in_idle;
   logic                 in_xfer;
   logic                 in_drain;
   logic                 beat_ok;
   logic                 cnt_end;

   assign in_idle  = (state == S_IDLE);
   assign in_xfer  = (state == S_ADDR) | (state == S_BURST);
   assign in_drain = (state == S_DRAIN);
   assign cnt_end  = (cnt == len);
   assign beat_ok  = in_xfer & HREADY;

   // A pending data phase blocks the next command so wdata_ready is settled.
   assign cmd_pop = in_idle & cmd_valid & wdata_ready & ~dphase;

   assign HADDR  = addr;
   assign HTRANS = !in_xfer ? 2'b00 : (state == S_ADDR) ? 2'b10 : 2'b11;
   assign HWRITE = in_xfer;
   assign HSIZE  = in_xfer ? {1'b0, size} : 3'b000;

   always_comb begin
      HBURST = 3'b000;
      if (in_xfer) begin
         if (len == LEN_BITS'(3))       HBURST = 3'b011;
         else if (len == LEN_BITS'(7))  HBURST = 3'b101;
         else if (len == LEN_BITS'(15)) HBURST = 3'b111;
         else                           HBURST = 3'b001;
      end
   end

   assign wdata_phase = dphase | in_drain;
   assign data_last   = HREADY & ((dphase & dlast) | (in_drain & cnt_end));
   assign busy        = ~in_idle | dphase;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (cmd_pop) state_nxt = cmd_err ? S_DRAIN : S_ADDR;
         S_ADDR, S_BURST:
            if (HREADY) state_nxt = cnt_end ? S_DEND : S_BURST;
         S_DEND, S_DRAIN:
            if (data_last) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         addr   <= '0;
         len    <= '0;
         cnt    <= '0;
         size   <= '0;
         dphase <= 1'b0;
         dlast  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cmd_pop) begin
            addr <= cmd_addr;
            len  <= cmd_len;
            size <= cmd_size;
            cnt  <= '0;
         end else if (beat_ok) begin
            addr <= addr + (ADDR_BITS'(1) << size);
            cnt  <= cnt + 1'b1;
         end else if (in_drain & HREADY) begin
            cnt <= cnt + 1'b1;
         end
         // Data phase trails its accepted address by one cycle.
         if (beat_ok) begin
            dphase <= 1'b1;
            dlast  <= cnt_end;
         end else if (HREADY) begin
            dphase <= 1'b0;
            dlast  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi2ahb_wr_ctrl.sv
// tb_axi2ahb_wr_ctrl: directed and random write bursts checked
// against a beat-level reference model of the AHB write sequencer.
module tb_axi2ahb_wr_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic [1:0]  cmd_size = '0;
   logic        cmd_err = 1'b0;
   logic        cmd_pop;
   logic        wdata_ready = 1'b0;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        HREADY = 1'b1;
   logic        wdata_phase;
   logic        data_last;
   logic        busy;

   int compared = 0;
   int mismatched = 0;
   int cycle = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   axi2ahb_wr_ctrl #(.ADDR_BITS(32), .LEN_BITS(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_size(cmd_size), .cmd_err(cmd_err), .cmd_pop(cmd_pop),
      .wdata_ready(wdata_ready),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HREADY(HREADY),
      .wdata_phase(wdata_phase), .data_last(data_last), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({HADDR, HTRANS, HWRITE, HSIZE, HBURST,
                  wdata_phase, data_last, cmd_pop, busy});
   endfunction

   // One command end to end; abort_at >= 0 pulls reset when that beat is up.
   task automatic run_cmd(input logic [31:0] a, input int l, input int sz,
                          input bit err, input int mode, input int hold,
                          input int abort_at);
      int acc, pops, t0, stall;
      bit done, ewp, edl;
      logic [1:0]  et;
      logic [2:0]  eb;
      logic [31:0] ea;
      eb = (l == 3) ? 3'b011 : (l == 7) ? 3'b101 :
           (l == 15) ? 3'b111 : 3'b001;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = 4'(l);
      cmd_size = 2'(sz); cmd_err = err; HREADY = 1'b1; wdata_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_nopop", 64'({cmd_pop, HTRANS}), 64'(0));
         @(posedge clk); #1;
      end
      wdata_ready = 1'b1;
      @(negedge clk);
      chk("cmd_pop", 64'(cmd_pop), 64'(1));
      t0 = cycle;
      acc = 0; pops = 0; stall = 0; done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; wdata_ready = 1'b0;
         if (mode == 1) HREADY = ($urandom_range(0, 3) != 0);
         else if (mode == 2 && acc == 1 && stall < 2) begin
            HREADY = 1'b0; stall++;
         end else HREADY = 1'b1;
         if (abort_at >= 0 && acc == abort_at) begin
            reset = 1'b0;
            @(negedge clk);
            chk("abort_outs", out_vec(), 64'(0));
            @(posedge clk); #1;
            reset = 1'b1; HREADY = 1'b1;
            return;
         end
         @(negedge clk);
         ewp = err ? (pops <= l) : (acc > pops);
         et  = (err || acc > l) ? 2'b00 : (acc == 0) ? 2'b10 : 2'b11;
         edl = ewp && HREADY && (pops == l);
         chk("htrans", 64'(HTRANS), 64'(et));
         chk("wdata_phase", 64'(wdata_phase), 64'(ewp));
         chk("data_last", 64'(data_last), 64'(edl));
         if (et != 2'b00) begin
            ea = a + 32'(acc << sz);
            chk("haddr", 64'(HADDR), 64'(ea));
            chk("hburst", 64'(HBURST), 64'(eb));
            chk("hsize", 64'(HSIZE), 64'(3'(sz)));
            chk("hwrite", 64'(HWRITE), 64'(1));
            if (HREADY) acc++;
         end
         if (wdata_phase && HREADY) pops++;
         if (data_last) begin
            done = 1'b1;
            if (mode == 0)
               chk("latency", 64'(cycle - t0), 64'(err ? l + 1 : l + 2));
         end
      end
      chk("timeout", 64'(done), 64'(1));
      chk("beats", {32'(acc), 32'(pops)},
          {32'(err ? 0 : l + 1), 32'(l + 1)});
      @(posedge clk); #1;
      HREADY = 1'b1;
      @(negedge clk);
      chk("idle_after", 64'({busy, HTRANS, wdata_phase}), 64'(0));
   endtask

   initial begin
      int l, sz, bytes, slots;
      logic [31:0] a;
      bit err;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", out_vec(), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;

      run_cmd(32'h100, 3, 2, 1'b0, 0, 0, -1);
      run_cmd(32'h100, 3, 2, 1'b0, 2, 0, -1);
      run_cmd(32'h200, 1, 2, 1'b0, 0, 10, -1);
      run_cmd(32'h300, 1, 2, 1'b1, 0, 0, -1);
      run_cmd(32'h3, 0, 0, 1'b0, 0, 0, -1);
      run_cmd(32'h1000, 15, 2, 1'b0, 0, 0, 2);
      run_cmd(32'h2000, 7, 1, 1'b0, 0, 0, -1);
      run_cmd(32'h3F0, 15, 0, 1'b0, 0, 0, -1);

      for (int k = 0; k < 25; k++) begin
         l     = $urandom_range(0, 15);
         sz    = $urandom_range(0, 2);
         err   = ($urandom_range(0, 4) == 0);
         bytes = (l + 1) << sz;
         slots = (1024 - bytes) >> sz;
         a     = ($urandom & 32'hFFFF_FC00) |
                 32'($urandom_range(0, slots) << sz);
         run_cmd(a, l, sz, err, 1, $urandom_range(0, 2), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
